// File: rtl/poly_unload_ctrl.sv
// rtl/poly_unload_ctrl.sv - streams one BRAM-resident polynomial out LSW first over valid/ready
// Reads are credit-limited against a small prefetch FIFO so stalls on m_tready never lose a word.
module poly_unload_ctrl #(
  parameter int R         = 10163,
  parameter int G_ADDR_W  = 8,
  parameter int G_DAT_W   = 64,
  parameter int G_DAT_DEP = 159,
  parameter int RD_LAT    = 2,
  parameter int FIFO_DEP  = 4
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [G_ADDR_W-1:0] mem_addra,
  output logic                mem_wea,
  input  logic [G_DAT_W-1:0]  mem_dina,
  output logic [G_DAT_W-1:0]  m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast
);

  localparam int CNT_W     = $clog2(FIFO_DEP + 1);
  localparam int SUM_W     = CNT_W + 1;
  localparam int PTR_W     = (FIFO_DEP > 1) ? $clog2(FIFO_DEP) : 1;
  localparam int LAST_BITS = R - (G_DAT_DEP - 1) * G_DAT_W;
  localparam logic [G_DAT_W-1:0]  LAST_MASK = {G_DAT_W{1'b1}} >> (G_DAT_W - LAST_BITS);
  localparam logic [G_ADDR_W-1:0] LAST_ADDR = G_ADDR_W'(G_DAT_DEP - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [G_ADDR_W-1:0] r_rd_ptr, r_addr, w_issue_ptr;
  logic                r_issued_all, r_done, w_issue, w_busy;
  logic [RD_LAT-1:0]   r_pipe_vld;
  logic [G_ADDR_W-1:0] r_pipe_tag [RD_LAT];
  logic [G_DAT_W-1:0]  r_fifo_data [FIFO_DEP];
  logic [FIFO_DEP-1:0] r_fifo_last;
  logic [PTR_W-1:0]    r_wr_idx, r_rd_idx;
  logic [CNT_W-1:0]    r_fifo_cnt, w_inflight;
  logic [SUM_W-1:0]    w_occ;
  logic                w_push, w_pop, w_push_last, w_last_acc, w_credit_ok;
  logic [G_DAT_W-1:0]  w_push_data;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEP - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_tvalid    = (r_fifo_cnt != '0);
  assign m_tdata     = r_fifo_data[r_rd_idx];
  assign m_tlast     = m_tvalid & r_fifo_last[r_rd_idx];
  assign w_pop       = m_tvalid & m_tready;
  assign w_last_acc  = (r_state == S_RUN) & w_pop & m_tlast;
  assign w_push      = r_pipe_vld[RD_LAT-1];
  assign w_push_last = (r_pipe_tag[RD_LAT-1] == LAST_ADDR);
  assign w_push_data = w_push_last ? (mem_dina & LAST_MASK) : mem_dina;
  assign busy        = w_busy;
  assign done        = r_done;
  assign mem_addra   = r_addr;
  assign mem_wea     = 1'b0;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CNT_W'(r_pipe_vld[i]);
    end
  end

  // A slot freed by this edge's pop is reusable immediately; occupancy still never exceeds FIFO_DEP.
  assign w_occ       = SUM_W'(r_fifo_cnt) + SUM_W'(w_inflight) - SUM_W'(w_pop);
  assign w_credit_ok = (w_occ < SUM_W'(FIFO_DEP));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)      w_state_nxt = S_RUN;
      S_RUN:   if (w_last_acc) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = 1'b0;
    w_issue     = 1'b0;
    w_issue_ptr = r_rd_ptr;
    case (r_state)
      S_IDLE: begin
        w_issue     = start;
        w_issue_ptr = '0;
      end
      S_RUN: begin
        w_busy  = 1'b1;
        w_issue = !r_issued_all && w_credit_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rd_ptr     <= '0;
      r_issued_all <= 1'b0;
      r_addr       <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_last_acc;
      if (w_last_acc) begin
        r_rd_ptr     <= '0;
        r_issued_all <= 1'b0;
        r_addr       <= '0;
      end else if (w_issue) begin
        r_addr <= w_issue_ptr;
        if (w_issue_ptr == LAST_ADDR) r_issued_all <= 1'b1;
        else                          r_rd_ptr     <= w_issue_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pipe_tag[i] <= '0;
    end else begin
      r_pipe_vld[0] <= w_issue;
      r_pipe_tag[0] <= w_issue_ptr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_fifo_cnt  <= '0;
      r_fifo_last <= '0;
      for (int i = 0; i < FIFO_DEP; i++) r_fifo_data[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_idx] <= w_push_data;
        r_fifo_last[r_wr_idx] <= w_push_last;
        r_wr_idx              <= f_inc(r_wr_idx);
      end
      if (w_pop) r_rd_idx <= f_inc(r_rd_idx);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_unload_ctrl.sv
// tb/tb_poly_unload_ctrl.sv - directed bench for poly_unload_ctrl (default build and RD_LAT=1/FIFO_DEP=2 build)
module tb_poly_unload_ctrl;
  localparam int DEP = 159;

  logic clk = 1'b0;
  logic rst_b, start0, ready0, start1, ready1;
  always #5 clk = ~clk;

  logic        busy0, done0, wea0, tvalid0, tlast0;
  logic [7:0]  addr0;
  logic [63:0] dina0, tdata0;
  logic        busy1, done1, wea1, tvalid1, tlast1;
  logic [7:0]  addr1;
  logic [63:0] dina1, tdata1;

  logic [63:0] bram [256];
  logic [63:0] bram_q0;
  always @(posedge clk) bram_q0 <= bram[addr0];
  assign dina0 = bram_q0;
  assign dina1 = bram[addr1];

  poly_unload_ctrl u_dut0 (
    .clk(clk), .rst_b(rst_b), .start(start0), .busy(busy0), .done(done0),
    .mem_addra(addr0), .mem_wea(wea0), .mem_dina(dina0),
    .m_tdata(tdata0), .m_tvalid(tvalid0), .m_tready(ready0), .m_tlast(tlast0)
  );

  poly_unload_ctrl #(.RD_LAT(1), .FIFO_DEP(2)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .start(start1), .busy(busy1), .done(done1),
    .mem_addra(addr1), .mem_wea(wea1), .mem_dina(dina1),
    .m_tdata(tdata1), .m_tvalid(tvalid1), .m_tready(ready1), .m_tlast(tlast1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] exp_word(input int i);
    if (i == DEP - 1) return 64'h0007_FFFF_FFFF_FFFF;
    return {32'hA5A5_0000 + 32'(i), 32'(i)};
  endfunction

  // Stream monitors, sampled on the falling edge.
  logic [63:0] q_data [$];
  logic        q_last [$];
  int done_cnt = 0, done_cyc = -1, rise_cyc = -1, stab_err = 0, ovf_err = 0;
  logic prev_vld = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  logic [63:0] prev_data = '0;
  always @(negedge clk) begin
    if (tvalid0 && !prev_vld) rise_cyc = cyc;
    if (prev_stall && rst_b && !(tvalid0 && tdata0 === prev_data && tlast0 === prev_last)) stab_err++;
    if (tvalid0 && ready0) begin
      q_data.push_back(tdata0);
      q_last.push_back(tlast0);
    end
    if (done0) begin done_cnt++; done_cyc = cyc; end
    if (int'(u_dut0.r_fifo_cnt) + int'(u_dut0.w_inflight) > 4) ovf_err++;
    prev_vld = tvalid0; prev_stall = tvalid0 && !ready0;
    prev_data = tdata0; prev_last = tlast0;
  end

  int n1 = 0, ord_err1 = 0, done_cnt1 = 0, done_cyc1 = -1, rise_cyc1 = -1;
  logic prev_vld1 = 1'b0;
  logic [63:0] last_word1 = '0;
  always @(negedge clk) begin
    if (tvalid1 && !prev_vld1) rise_cyc1 = cyc;
    if (tvalid1 && ready1) begin
      if (tdata1 !== exp_word(n1) || tlast1 !== (n1 == DEP - 1)) ord_err1++;
      if (tlast1) last_word1 = tdata1;
      n1++;
    end
    if (done1) begin done_cnt1++; done_cyc1 = cyc; end
    prev_vld1 = tvalid1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high; mode 1: ready 1,0,0,1; mode 2: ready high plus start pulses early in the run
  task automatic wait_done0(input int limit, input int mode);
    int b;
    b = done_cnt;
    for (int k = 0; k < limit; k++) begin
      if (done_cnt != b) break;
      ready0 = (mode == 1) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      start0 = (mode == 2) && (k < 100) && (k % 3 == 0);
      tick();
    end
    start0 = 1'b0;
  endtask

  task automatic check_run(input string tag, input int base);
    chk({tag, "_beat_count"}, 64'(q_data.size() - base), 64'(DEP));
    for (int i = 0; i < DEP && base + i < q_data.size(); i++) begin
      chk($sformatf("%s_beat%0d_data", tag, i), q_data[base + i], exp_word(i));
      chk($sformatf("%s_beat%0d_last", tag, i), 64'(q_last[base + i]), 64'(i == DEP - 1));
    end
  endtask

  int base, dbase, e0, snap;

  initial begin
    for (int i = 0; i < 256; i++)
      bram[i] = (i < DEP - 1) ? {32'hA5A5_0000 + 32'(i), 32'(i)} : ((i == DEP - 1) ? '1 : '0);
    rst_b = 1'b0; start0 = 1'b0; ready0 = 1'b0; start1 = 1'b0; ready1 = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy0), 0);
    chk("rst_done", 64'(done0), 0);
    chk("rst_tvalid", 64'(tvalid0), 0);
    chk("rst_tlast", 64'(tlast0), 0);
    chk("rst_tdata", tdata0, 0);
    chk("rst_addr", 64'(addr0), 0);
    chk("rst_wea", 64'(wea0), 0);
    rst_b = 1'b1;
    tick();

    // 1: continuous ready, latency and masking
    ready0 = 1'b1; base = q_data.size(); dbase = done_cnt;
    start0 = 1'b1; tick(); start0 = 1'b0; e0 = cyc;
    chk("t1_busy", 64'(busy0), 1);
    wait_done0(400, 0);
    chk("t1_done_cnt", 64'(done_cnt - dbase), 1);
    chk("t1_first_valid_edge", 64'(rise_cyc - e0), 2);
    chk("t1_done_edge", 64'(done_cyc - e0), 161);
    check_run("t1", base);
    tick();
    chk("t1_busy_after", 64'(busy0), 0);
    chk("t1_tvalid_after", 64'(tvalid0), 0);
    chk("t1_addr_after", 64'(addr0), 0);

    // 2: ready toggling 1,0,0,1
    base = q_data.size(); dbase = done_cnt;
    start0 = 1'b1; tick(); start0 = 1'b0;
    wait_done0(1000, 1);
    ready0 = 1'b1;
    repeat (3) tick();
    chk("t2_done_cnt", 64'(done_cnt - dbase), 1);
    check_run("t2", base);
    chk("t2_no_overflow", 64'(ovf_err), 0);
    chk("t2_stable_on_stall", 64'(stab_err), 0);

    // 3: ready low for 20 cycles after start
    ready0 = 1'b0; base = q_data.size(); dbase = done_cnt;
    start0 = 1'b1; tick(); start0 = 1'b0; e0 = cyc;
    tick(); tick();
    chk("t3_addr_edge2", 64'(addr0), 2);
    repeat (17) tick();
    chk("t3_addr_stall", 64'(addr0), 3);
    chk("t3_no_beats", 64'(q_data.size() - base), 0);
    chk("t3_valid_held", 64'(tvalid0), 1);
    wait_done0(400, 0);
    chk("t3_done_cnt", 64'(done_cnt - dbase), 1);
    chk("t3_done_edge", 64'(done_cyc - e0), 178);
    check_run("t3", base);
    chk("t3_stable_on_stall", 64'(stab_err), 0);
    chk("t3_no_overflow", 64'(ovf_err), 0);

    // 4: async reset at beat 50
    ready0 = 1'b1; base = q_data.size(); dbase = done_cnt;
    start0 = 1'b1; tick(); start0 = 1'b0;
    for (int k = 0; k < 200 && q_data.size() - base < 50; k++) tick();
    chk("t4_reached_beat50", 64'(q_data.size() - base), 50);
    #2 rst_b = 1'b0;
    #1;
    chk("t4_busy", 64'(busy0), 0);
    chk("t4_tvalid", 64'(tvalid0), 0);
    chk("t4_tlast", 64'(tlast0), 0);
    chk("t4_tdata", tdata0, 0);
    chk("t4_addr", 64'(addr0), 0);
    chk("t4_done", 64'(done0), 0);
    tick();
    rst_b = 1'b1;
    snap = q_data.size();
    repeat (10) tick();
    chk("t4_no_beats_after", 64'(q_data.size() - snap), 0);
    chk("t4_no_done", 64'(done_cnt - dbase), 0);
    chk("t4_idle", 64'(busy0), 0);

    // 5: fresh start after abort, start pulsed during RUN
    base = q_data.size(); dbase = done_cnt;
    start0 = 1'b1; tick(); start0 = 1'b0;
    wait_done0(400, 2);
    repeat (5) tick();
    chk("t5_done_cnt", 64'(done_cnt - dbase), 1);
    check_run("t5", base);
    chk("t5_idle", 64'(busy0), 0);

    // 6: RD_LAT=1, FIFO_DEP=2 build
    ready1 = 1'b1;
    start1 = 1'b1; tick(); start1 = 1'b0; e0 = cyc;
    for (int k = 0; k < 400 && done_cnt1 == 0; k++) tick();
    tick();
    chk("t6_done_cnt", 64'(done_cnt1), 1);
    chk("t6_first_valid_edge", 64'(rise_cyc1 - e0), 1);
    chk("t6_done_edge", 64'(done_cyc1 - e0), 160);
    chk("t6_beats", 64'(n1), 64'(DEP));
    chk("t6_order", 64'(ord_err1), 0);
    chk("t6_last_word", last_word1, 64'h0007_FFFF_FFFF_FFFF);
    chk("t6_idle", 64'(busy1), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
